// File: rtl/alu_pkg.sv
// alu_pkg: shared op-codes, data width and sequencer state encoding for the ALU stage.
package alu_pkg;

    localparam int ALU_W = 4;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_acc_seq.sv
// alu_acc_seq: handshaked command sequencer wrapping a combinational 4-bit ALU,
// repeating acc = acc op B for cmd_rep+1 iterations and returning the result.
module alu_acc_seq
    import alu_pkg::*;
#(
    parameter int REP_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_sel,
    input  logic [ALU_W-1:0] cmd_a,
    input  logic             cmd_use_acc,
    input  logic [ALU_W-1:0] cmd_b,
    input  logic [REP_W-1:0] cmd_rep,
    output logic [2:0]       alu_sel,
    output logic [ALU_W-1:0] alu_a,
    output logic [ALU_W-1:0] alu_b,
    input  logic [ALU_W:0]   alu_o,
    input  logic             alu_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ALU_W-1:0] res_data,
    output logic             res_carry,
    output logic             res_zero,
    output logic             res_neg,
    output logic [ALU_W-1:0] acc_q
);

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [ALU_W-1:0]   a_q, a_d, b_q, b_d, acc_d, res_q, res_d;
    logic [REP_W-1:0]   cnt_q, cnt_d;
    logic               cy_q, cy_d, rcy_q, rcy_d;
    logic               unused_o4;

    // ALU bit 4 duplicates the carry line, so only the low nibble is consumed.
    assign unused_o4 = alu_o[ALU_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            rcy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            rcy_q   <= rcy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        rcy_d   = rcy_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                sel_d   = cmd_sel;
                a_d     = cmd_use_acc ? acc_q : cmd_a;
                b_d     = cmd_b;
                cnt_d   = cmd_rep;
                cy_d    = 1'b0;
                state_d = EXEC;
            end
            EXEC: begin
                acc_d = alu_o[ALU_W-1:0];
                cy_d  = cy_q | alu_carry;
                if (cnt_q == '0) begin
                    res_d   = alu_o[ALU_W-1:0];
                    rcy_d   = cy_q | alu_carry;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - REP_W'(1);
                    a_d   = alu_o[ALU_W-1:0];
                end
            end
            HOLD: state_d = res_ready ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = state_q == IDLE;
    assign res_valid = state_q == HOLD;
    assign alu_sel   = sel_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign res_data  = res_q;
    assign res_carry = rcy_q;
    assign res_zero  = res_q == '0;
    assign res_neg   = res_q[ALU_W-1];

endmodule
